// File: rtl/stepper_seq.sv
// Unipolar stepper sequencer: command-driven moves of N half/full steps at a
// programmable rate, with absolute position tracking and a completion pulse.
module stepper_seq #(
  parameter int DIV_W       = 24,
  parameter int STEP_W      = 16,
  parameter int POS_W       = 16,
  parameter int HOLD_TORQUE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stop,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic [DIV_W-1:0]  cmd_div,
  output logic [3:0]        motor_out,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          idx_reg, idx_next, idx_step;
  logic [POS_W-1:0]    pos_reg;
  logic [STEP_W-1:0]   left_reg;
  logic [DIV_W-1:0]    cnt_reg, div_reg;
  logic                dir_reg, half_reg;
  logic [3:0]          motor_reg, motor_next;
  logic                done_reg, zero_pend_reg;
  logic                accept, tick, last_step;

  function automatic logic [3:0] coil(input logic [2:0] i);
    case (i)
      3'd0:    coil = 4'b0111;
      3'd1:    coil = 4'b0011;
      3'd2:    coil = 4'b1011;
      3'd3:    coil = 4'b1001;
      3'd4:    coil = 4'b1101;
      3'd5:    coil = 4'b1100;
      3'd6:    coil = 4'b1110;
      default: coil = 4'b0110;
    endcase
  endfunction

  assign cmd_ready = (state_reg == IDLE) && en;
  assign accept    = cmd_valid && cmd_ready;
  // stop takes priority over a coincident tick, so an aborted move never steps
  assign tick      = (state_reg == RUN) && en && !stop && (cnt_reg == div_reg);
  assign last_step = tick && (left_reg == STEP_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept && (cmd_steps != '0)) state_next = RUN;
      RUN:  if (stop || last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Full-step lands on odd indices (two coils energised) in the move direction
  always_comb begin
    idx_step = idx_reg;
    if (half_reg)
      idx_step = dir_reg ? idx_reg + 3'd1 : idx_reg - 3'd1;
    else if (dir_reg)
      idx_step = idx_reg + 3'd1 + {2'b00, idx_reg[0]};
    else
      idx_step = idx_reg - 3'd1 - {2'b00, idx_reg[0]};
  end

  always_comb begin
    idx_next   = tick ? idx_step : idx_reg;
    motor_next = 4'b1111;
    if (en && ((state_next == RUN) || (HOLD_TORQUE != 0)))
      motor_next = coil(idx_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      pos_reg       <= '0;
      left_reg      <= '0;
      cnt_reg       <= '0;
      div_reg       <= '0;
      dir_reg       <= 1'b0;
      half_reg      <= 1'b0;
      motor_reg     <= 4'b1111;
      done_reg      <= 1'b0;
      zero_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      motor_reg     <= motor_next;
      done_reg      <= zero_pend_reg || last_step;
      zero_pend_reg <= accept && (cmd_steps == '0);
      if (accept) begin
        left_reg <= cmd_steps;
        div_reg  <= cmd_div;
        dir_reg  <= cmd_dir;
        half_reg <= cmd_half;
        cnt_reg  <= '0;
      end else if ((state_reg == RUN) && en && !stop) begin
        cnt_reg <= (cnt_reg == div_reg) ? '0 : cnt_reg + DIV_W'(1);
        if (tick) left_reg <= left_reg - STEP_W'(1);
      end
      if (tick) pos_reg <= dir_reg ? pos_reg + POS_W'(1) : pos_reg - POS_W'(1);
    end
  end

  assign motor_out = motor_reg;
  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign position  = pos_reg;

endmodule

// File: tb/tb_stepper_seq.sv
// Bench for stepper_seq: two instances (hold/16-bit position and release/4-bit
// position) share stimulus and are compared every cycle to a step-schedule model.
module tb_stepper_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, stop = 1'b0, cmd_valid = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic        cmd_dir = 1'b0, cmd_half = 1'b0;
  logic [23:0] cmd_div = '0;

  logic        ready_a, busy_a, done_a, ready_b, busy_b, done_b;
  logic [3:0]  motor_a, motor_b;
  logic [15:0] pos_a;
  logic [3:0]  pos_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  stepper_seq dut_a (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_div(cmd_div),
    .motor_out(motor_a), .busy(busy_a), .done(done_a), .position(pos_a)
  );

  stepper_seq #(.POS_W(4), .HOLD_TORQUE(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .stop(stop), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_div(cmd_div),
    .motor_out(motor_b), .busy(busy_b), .done(done_b), .position(pos_b)
  );

  // Reference model: a move is N steps, step k lands after k*(div+1) enabled cycles
  logic [3:0] coil_tab [8] = '{4'b0111, 4'b0011, 4'b1011, 4'b1001,
                               4'b1101, 4'b1100, 4'b1110, 4'b0110};
  bit       m_run, m_dir, m_half, m_done, m_zero;
  int       m_idx, m_pos, m_left, m_div, m_elapsed;
  logic [3:0] m_ma, m_mb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_idx(input int i, input bit d, input bit h);
    int n = i;
    do n = (n + (d ? 1 : 7)) % 8; while (!h && (n % 2) == 0);
    return n;
  endfunction

  task automatic model_reset();
    m_run = 0; m_dir = 0; m_half = 0; m_done = 0; m_zero = 0;
    m_idx = 0; m_pos = 0; m_left = 0; m_div = 0; m_elapsed = 0;
    m_ma = 4'hF; m_mb = 4'hF;
  endtask

  task automatic model_update();
    bit done_n;
    if (rst) begin
      model_reset();
      return;
    end
    done_n = m_zero;
    m_zero = 0;
    if (m_run) begin
      if (stop) m_run = 0;
      else if (en) begin
        m_elapsed++;
        if (m_elapsed % (m_div + 1) == 0) begin
          m_idx = next_idx(m_idx, m_dir, m_half);
          m_pos += m_dir ? 1 : -1;
          m_left--;
          if (m_left == 0) begin m_run = 0; done_n = 1; end
        end
      end
    end else if (en && cmd_valid) begin
      $display("cmd steps=%0d dir=%0d half=%0d div=%0d at %0t",
               cmd_steps, cmd_dir, cmd_half, cmd_div, $time);
      if (cmd_steps == 0) m_zero = 1;
      else begin
        m_run = 1; m_left = cmd_steps; m_div = cmd_div;
        m_dir = cmd_dir; m_half = cmd_half; m_elapsed = 0;
      end
    end
    m_done = done_n;
    m_ma = en ? coil_tab[m_idx] : 4'hF;
    m_mb = (en && m_run) ? coil_tab[m_idx] : 4'hF;
  endtask

  // Called at a negedge with inputs set; advances one clock and checks outputs
  task automatic step_cycle();
    #1;
    check("ready_a", 32'(ready_a), 32'(!m_run && en));
    check("ready_b", 32'(ready_b), 32'(!m_run && en));
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("motor_a", 32'(motor_a), 32'(m_ma));
    check("motor_b", 32'(motor_b), 32'(m_mb));
    check("busy_a",  32'(busy_a),  32'(m_run));
    check("busy_b",  32'(busy_b),  32'(m_run));
    check("done_a",  32'(done_a),  32'(m_done));
    check("done_b",  32'(done_b),  32'(m_done));
    check("pos_a",   32'(pos_a),   32'(m_pos) & 32'hFFFF);
    check("pos_b",   32'(pos_b),   32'(m_pos) & 32'hF);
  endtask

  task automatic issue(input int steps, input bit dir, input bit half, input int div);
    cmd_valid = 1; cmd_steps = 16'(steps); cmd_dir = dir; cmd_half = half; cmd_div = 24'(div);
    step_cycle();
    cmd_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; step_cycle(); rst = 0;
  endtask

  initial begin
    int done_at;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 1;
    do_reset();
    check("reset_motor", 32'(motor_a), 32'hF);
    check("reset_pos", 32'(pos_a), 32'h0);

    // Half-step forward, 8 steps at div=3: done 32 cycles after acceptance
    issue(8, 1, 1, 3);
    done_at = -1;
    for (int i = 1; i <= 40; i++) begin
      step_cycle();
      if (done_a && done_at < 0) done_at = i;
    end
    check("half_done_at", 32'(done_at), 32'd32);
    check("half_pos", 32'(pos_a), 32'd8);

    // Full-step backward from index 0
    do_reset();
    issue(3, 0, 0, 0);
    step_cycle(); check("full_p1", 32'(motor_a), 32'b0110);
    step_cycle(); check("full_p2", 32'(motor_a), 32'b1100);
    step_cycle(); check("full_p3", 32'(motor_a), 32'b1001);
    check("full_pos", 32'(pos_a), 32'hFFFD);

    // Abort on the cycle of the 5th tick
    do_reset();
    issue(100, 1, 1, 9);
    repeat (49) step_cycle();
    stop = 1; step_cycle(); stop = 0;
    check("abort_pos", 32'(pos_a), 32'd4);
    check("abort_busy", 32'(busy_a), 32'd0);
    repeat (12) step_cycle();

    // Enable gap of 7 cycles mid-move; done slips by exactly 7 cycles
    do_reset();
    issue(6, 1, 0, 2);
    done_at = -1;
    for (int i = 1; i <= 40; i++) begin
      en = !(i >= 6 && i <= 12);
      step_cycle();
      if (!en) check("gap_motor", 32'(motor_b), 32'hF);
      if (done_a && done_at < 0) done_at = i;
    end
    en = 1;
    check("gap_done_at", 32'(done_at), 32'd25);
    check("gap_release", 32'(motor_b), 32'hF);

    // Zero-step command: done one cycle after acceptance, never busy
    issue(0, 1, 1, 5);
    check("zero_done0", 32'(done_a), 32'd0);
    step_cycle();
    check("zero_done1", 32'(done_a), 32'd1);
    check("zero_busy", 32'(busy_a), 32'd0);

    // Commands while busy are ignored
    issue(4, 1, 1, 1);
    cmd_valid = 1; cmd_steps = 16'd50; cmd_dir = 0;
    repeat (12) step_cycle();
    cmd_valid = 0;

    // Reset mid-move
    issue(20, 1, 1, 1);
    repeat (5) step_cycle();
    do_reset();
    check("rst_pos", 32'(pos_a), 32'd0);
    check("rst_motor", 32'(motor_a), 32'hF);

    // Position wrap on the 4-bit instance
    issue(9, 0, 1, 0);
    repeat (10) step_cycle();
    check("wrap_pos_b", 32'(pos_b), 32'b0111);
    check("wrap_pos_a", 32'(pos_a), 32'hFFF7);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 399) == 0);
      en        = ($urandom_range(0, 19) != 0);
      stop      = ($urandom_range(0, 59) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_steps = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 10));
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_half  = 1'($urandom_range(0, 1));
      cmd_div   = 24'($urandom_range(0, 3));
      step_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_seq.md
# stepper_seq

Parametrised unipolar stepper-motor sequencer that drives the 4-bit active-low coil bus (`motor_out`) of the curtain motor. It replaces the fixed-direction, fixed-rate half-step rotators. Each move is a command carrying a step count, with direction, half/full-step mode and step rate latched per command. The block tracks absolute position and reports completion, so the light-control logic can position the curtain rather than just spin the motor.

## Interface
Parameters:
- `DIV_W`, 24: width of the step-rate divider.
- `STEP_W`, 16: width of the step-count field in a command.
- `POS_W`, 16: width of the position counter (two's complement, wraps).
- `HOLD_TORQUE`, 1: 1 = keep the last coil pattern energised when idle; 0 = drive 4'b1111 (all coils off) when idle.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable; 0 forces coils off and freezes motion.
- `stop` in 1: abort the current move.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_steps` in STEP_W: number of steps to move.
- `cmd_dir` in 1: 1 = forward (table index increments), 0 = backward.
- `cmd_half` in 1: 1 = half-step mode, 0 = full-step (two-phase) mode.
- `cmd_div` in DIV_W: step period minus one, in `clk` cycles.
- `motor_out` out 4: coil drive pattern, active-low.
- `busy` out 1: a move is in progress.
- `done` out 1: one-cycle pulse when a move completes normally.
- `position` out POS_W: signed step count since reset.

## Operation
- Coil table, index 0..7: 4'b0111, 0011, 1011, 1001, 1101, 1100, 1110, 0110. The index is 3 bits and wraps modulo 8.
- Half-step: each step moves the index ±1.
- Full-step: each step moves the index to the next odd index in the current direction.
  - Forward: even idx → idx+1; odd idx → idx+2.
  - Backward: even idx → idx−1; odd idx → idx−2.
- `position` changes by +1 (forward) or −1 (backward) per step, in either mode, and wraps modulo 2^POS_W.
- FSM states and transitions:
  - IDLE → RUN when `cmd_valid && cmd_ready`. On acceptance the block latches dir, half, div and steps, and clears the divider counter.
  - RUN → IDLE when the remaining count reaches 0 (normal completion) or when `stop` is high (abort).
- `cmd_ready` = (state==IDLE) && `en`. While busy, `cmd_valid` is ignored; there is no queueing.
- Divider: in RUN with `en`=1, the counter counts 0..div. A step tick fires on the wrap. `div`=0 gives one step per cycle.
- `cmd_steps`=0: the command is accepted, no step occurs, `busy` stays 0, and `done` pulses on the next cycle.
- `stop` in RUN:
  - Enter IDLE at the next edge.
  - No `done` pulse.
  - `position` and index keep their last stepped values.
  - If `stop` and a tick coincide, `stop` wins and no step occurs.
- `en`=0 in RUN:
  - `motor_out` = 4'b1111.
  - Divider and remaining count are frozen.
  - On re-enable, the move resumes with the same divider phase.
- `motor_out`:
  - RUN with `en`=1: table[idx].
  - IDLE: table[idx] if `HOLD_TORQUE`, else 4'b1111.
  - `en`=0: always 4'b1111.
- Reset (`rst`=1 at an edge): state IDLE, idx 0, `motor_out` 4'b1111, `position` 0, `busy` 0, `done` 0, remaining 0, divider 0. `cmd_ready` = `en` after reset. Reset mid-move aborts the move immediately with no `done`.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state and `en`.
- Command accepted at edge A: `busy`=1 from A.
- Step k (k=1..N) updates `motor_out` and `position` at edge A + k·(div+1), assuming `en` is held at 1.
- At the final step edge, `busy`→0 and `done`→1 for exactly one cycle. `cmd_ready` returns to 1 at that same edge, so a new command can be accepted in the `done` cycle.
- Total move latency: N·(div+1) cycles from acceptance to the `done` cycle.

## Test plan
- Half-step forward: reset, then command steps=8, dir=1, half=1, div=3. `motor_out` visits 0011,1011,1001,1101,1100,1110,0110,0111, one pattern every 4 cycles. `done` is high exactly 32 cycles after acceptance, and `position`=8.
- Full-step backward from idx 0: steps=3, dir=0, half=0, div=0. Patterns are 0110, 1100, 1001 on consecutive cycles, and `position`=−3 (0xFFFD).
- Abort: steps=100, div=9, `stop` pulsed at the cycle of the 5th tick. Exactly 4 steps occur, `position`=4, `done` never asserts, and `cmd_ready`=1 on the next cycle.
- Enable gating and idle release: with HOLD_TORQUE=0, drop `en` for 7 cycles mid-move. `motor_out`=1111 during the gap, and step spacing resumes with no lost or extra steps. After `done`, `motor_out`=1111.
- Edge cases:
  - steps=0: `done` pulses one cycle after acceptance and `busy` stays 0.
  - `cmd_valid` while busy: no effect.
  - `rst` asserted mid-move: `motor_out`=1111, `position`=0, `busy`=0 at the next edge.
  - Position wrap: with POS_W=4, 9 backward steps from 0 give `position`=4'b0111.
